wbc_master_arbiter: RTL and testbench

// - Round-robin arbiter sharing the 20-bit WISHBONE control bus among the control masters (PCI, TURF, HK, VIO).
// - Sits in front of the slave decode in wbc_intercon and presents a single master view to the slave side.
// - A watchdog aborts a stalled transfer with an ERR, so a dead slave cannot lock the PCI or VIO path.

---
 rtl/wbc_master_arbiter_pkg.sv | 20 ++
 rtl/wbc_rr_pick.sv | 36 +++
 rtl/wbc_master_arbiter.sv | 164 ++++++++++++++++
 tb/tb_wbc_master_arbiter.sv | 334 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/wbc_master_arbiter_pkg.sv
// Shared definitions for the control-bus master arbiter: FSM states,
// master index constants and a small width helper.
package wbc_master_arbiter_pkg;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_OWN   = 2'd1,
      ST_ABORT = 2'd2
   } arb_state_t;

   localparam int M_PCIC  = 0;
   localparam int M_TURFC = 1;
   localparam int M_HKMC  = 2;
   localparam int M_WBVIO = 3;

   function automatic int idx_width(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/wbc_rr_pick.sv
// Combinational round-robin picker: first requester at or after (last+1) mod NM.
// Returns a one-hot grant, its index and a valid flag.
module wbc_rr_pick
   import wbc_master_arbiter_pkg::*;
#(
   parameter int NM = 4,
   parameter int LW = idx_width(NM)
)(
   input  logic [NM-1:0] req,
   input  logic [LW-1:0] last,
   output logic [NM-1:0] gnt,
   output logic [LW-1:0] idx,
   output logic          valid
);

   int            cand;
   logic [LW-1:0] cand_idx;

   always_comb begin
      gnt      = '0;
      idx      = '0;
      valid    = 1'b0;
      cand     = 0;
      cand_idx = '0;
      for (int k = 1; k <= NM; k++) begin
         cand     = (int'(last) + k) % NM;
         cand_idx = cand[LW-1:0];
         if (!valid && req[cand_idx]) begin
            valid         = 1'b1;
            gnt[cand_idx] = 1'b1;
            idx           = cand_idx;
         end
      end
   end

endmodule

// File: rtl/wbc_master_arbiter.sv
// Round-robin arbiter presenting one WISHBONE master view of the control bus,
// with a watchdog that aborts a stalled transfer by returning ERR to the owner.
module wbc_master_arbiter
   import wbc_master_arbiter_pkg::*;
#(
   parameter int NM  = 4,
   parameter int AW  = 20,
   parameter int DW  = 32,
   parameter int SW  = 4,
   parameter int TMO = 255
)(
   input  logic            clk_i,
   input  logic            rst_n_i,
   input  logic [NM-1:0]   m_cyc_i,
   input  logic [NM-1:0]   m_stb_i,
   input  logic [NM-1:0]   m_we_i,
   input  logic [NM*AW-1:0] m_adr_i,
   input  logic [NM*DW-1:0] m_dat_i,
   input  logic [NM*SW-1:0] m_sel_i,
   output logic [DW-1:0]   m_dat_o,
   output logic [NM-1:0]   m_ack_o,
   output logic [NM-1:0]   m_err_o,
   output logic [NM-1:0]   m_rty_o,
   output logic            s_cyc_o,
   output logic            s_stb_o,
   output logic            s_we_o,
   output logic [AW-1:0]   s_adr_o,
   output logic [DW-1:0]   s_dat_o,
   output logic [SW-1:0]   s_sel_o,
   input  logic [DW-1:0]   s_dat_i,
   input  logic            s_ack_i,
   input  logic            s_err_i,
   input  logic            s_rty_i,
   output logic [NM-1:0]   grant_o,
   output logic            timeout_o
);

   localparam int LW = idx_width(NM);
   localparam int CW = (TMO > 0) ? $clog2(TMO + 1) : 1;
   // The abort fires during the stalled cycle that would bring the count to TMO.
   localparam logic [CW-1:0] WDOG_LAST = (TMO > 0) ? CW'(TMO - 1) : '0;

   arb_state_t    state_reg, state_next;
   logic [NM-1:0] grant_reg, grant_next;
   logic [LW-1:0] last_reg, last_next;
   logic [CW-1:0] wdog_reg, wdog_next;

   logic [NM-1:0] pick_gnt;
   logic [LW-1:0] pick_idx;
   logic          pick_valid;

   logic [AW-1:0] adr_arr [NM];
   logic [DW-1:0] dat_arr [NM];
   logic [SW-1:0] sel_arr [NM];

   logic          own_cyc, own_stb, own_we;
   logic [AW-1:0] own_adr;
   logic [DW-1:0] own_dat;
   logic [SW-1:0] own_sel;
   logic          fwd, term, stall, abort;

   for (genvar gi = 0; gi < NM; gi++) begin : g_unpack
      assign adr_arr[gi] = m_adr_i[gi*AW +: AW];
      assign dat_arr[gi] = m_dat_i[gi*DW +: DW];
      assign sel_arr[gi] = m_sel_i[gi*SW +: SW];
   end

   wbc_rr_pick #(.NM(NM), .LW(LW)) u_pick (
      .req   (m_cyc_i),
      .last  (last_reg),
      .gnt   (pick_gnt),
      .idx   (pick_idx),
      .valid (pick_valid)
   );

   always_comb begin
      own_cyc = 1'b0;
      own_stb = 1'b0;
      own_we  = 1'b0;
      own_adr = '0;
      own_dat = '0;
      own_sel = '0;
      for (int k = 0; k < NM; k++) begin
         if (grant_reg[k]) begin
            own_cyc = m_cyc_i[k];
            own_stb = m_stb_i[k];
            own_we  = m_we_i[k];
            own_adr = adr_arr[k];
            own_dat = dat_arr[k];
            own_sel = sel_arr[k];
         end
      end
   end

   assign fwd   = (state_reg == ST_OWN) && own_cyc;
   assign term  = s_ack_i | s_err_i | s_rty_i;
   assign stall = fwd && own_stb && !term;
   assign abort = (TMO > 0) && stall && (wdog_reg == WDOG_LAST);

   assign s_cyc_o   = fwd && !abort;
   assign s_stb_o   = fwd && own_stb && !abort;
   assign s_we_o    = fwd && own_we;
   assign s_adr_o   = fwd ? own_adr : '0;
   assign s_dat_o   = fwd ? own_dat : '0;
   assign s_sel_o   = fwd ? own_sel : '0;
   assign m_dat_o   = s_dat_i;
   assign m_ack_o   = fwd ? (grant_reg & {NM{s_ack_i}}) : '0;
   assign m_err_o   = fwd ? (grant_reg & {NM{s_err_i | abort}}) : '0;
   assign m_rty_o   = fwd ? (grant_reg & {NM{s_rty_i}}) : '0;
   assign grant_o   = grant_reg;
   assign timeout_o = abort;

   always_comb begin
      state_next = state_reg;
      grant_next = grant_reg;
      last_next  = last_reg;
      wdog_next  = '0;
      case (state_reg)
         ST_IDLE: begin
            if (pick_valid) begin
               state_next = ST_OWN;
               grant_next = pick_gnt;
               last_next  = pick_idx;
            end
         end
         ST_OWN: begin
            if (!own_cyc) begin
               state_next = ST_IDLE;
               grant_next = '0;
            end else if (abort) begin
               state_next = ST_ABORT;
            end else if (stall && (TMO > 0)) begin
               wdog_next = wdog_reg + 1'b1;
            end
         end
         ST_ABORT: begin
            // Late slave terminations are dropped here because fwd is low.
            if (!own_cyc) begin
               state_next = ST_IDLE;
               grant_next = '0;
            end
         end
         default: begin
            state_next = ST_IDLE;
            grant_next = '0;
         end
      endcase
   end

   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         state_reg <= ST_IDLE;
         grant_reg <= '0;
         last_reg  <= LW'(NM - 1);
         wdog_reg  <= '0;
      end else begin
         state_reg <= state_next;
         grant_reg <= grant_next;
         last_reg  <= last_next;
         wdog_reg  <= wdog_next;
      end
   end

endmodule

// File: tb/tb_wbc_master_arbiter.sv
// Self-checking bench for wbc_master_arbiter: directed scenarios followed by
// random traffic, all compared against a cycle-level behavioural model.
module tb_wbc_master_arbiter;

   localparam int NM  = 4;
   localparam int AW  = 20;
   localparam int DW  = 32;
   localparam int SW  = 4;
   localparam int TMO = 8;

   logic              clk = 1'b0;
   logic              rst_n;
   logic [NM-1:0]     m_cyc, m_stb, m_we;
   logic [NM*AW-1:0]  m_adr;
   logic [NM*DW-1:0]  m_dat;
   logic [NM*SW-1:0]  m_sel;
   logic [DW-1:0]     m_dat_o;
   logic [NM-1:0]     m_ack_o, m_err_o, m_rty_o;
   logic              s_cyc_o, s_stb_o, s_we_o;
   logic [AW-1:0]     s_adr_o;
   logic [DW-1:0]     s_dat_o;
   logic [SW-1:0]     s_sel_o;
   logic [DW-1:0]     s_dat;
   logic              s_ack, s_err, s_rty;
   logic [NM-1:0]     grant_o;
   logic              timeout_o;

   int checks   = 0;
   int failures = 0;

   // Model state: md 0=idle, 1=owned, 2=aborted; own = owning master index.
   int md, own, last_m, stall;

   wbc_master_arbiter #(.NM(NM), .AW(AW), .DW(DW), .SW(SW), .TMO(TMO)) dut (
      .clk_i(clk), .rst_n_i(rst_n),
      .m_cyc_i(m_cyc), .m_stb_i(m_stb), .m_we_i(m_we),
      .m_adr_i(m_adr), .m_dat_i(m_dat), .m_sel_i(m_sel),
      .m_dat_o(m_dat_o), .m_ack_o(m_ack_o), .m_err_o(m_err_o), .m_rty_o(m_rty_o),
      .s_cyc_o(s_cyc_o), .s_stb_o(s_stb_o), .s_we_o(s_we_o),
      .s_adr_o(s_adr_o), .s_dat_o(s_dat_o), .s_sel_o(s_sel_o),
      .s_dat_i(s_dat), .s_ack_i(s_ack), .s_err_i(s_err), .s_rty_i(s_rty),
      .grant_o(grant_o), .timeout_o(timeout_o)
   );

   initial forever #5 clk = ~clk;

   task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   function automatic logic [NM-1:0] m_owner_mask();
      return (md == 0) ? '0 : (NM'(1) << own);
   endfunction

   function automatic logic m_fwd();
      return (md == 1) && m_cyc[own];
   endfunction

   function automatic logic m_abort();
      return m_fwd() && m_stb[own] && !(s_ack || s_err || s_rty) && (stall == TMO - 1);
   endfunction

   task automatic compare_outputs();
      logic [NM-1:0] ob;
      logic          fw, ab;
      logic [56:0]   bus_exp;
      ob = m_owner_mask();
      fw = m_fwd();
      ab = m_abort();
      bus_exp = fw ? {m_we[own], m_sel[own*SW +: SW], m_adr[own*AW +: AW], m_dat[own*DW +: DW]} : '0;
      chk("grant",   128'(grant_o), 128'(ob));
      chk("s_cyc",   128'(s_cyc_o), 128'(fw && !ab));
      chk("s_stb",   128'(s_stb_o), 128'(fw && m_stb[own] && !ab));
      chk("s_bus",   128'({s_we_o, s_sel_o, s_adr_o, s_dat_o}), 128'(bus_exp));
      chk("m_ack",   128'(m_ack_o), 128'((fw && s_ack) ? ob : '0));
      chk("m_err",   128'(m_err_o), 128'((fw && (s_err || ab)) ? ob : '0));
      chk("m_rty",   128'(m_rty_o), 128'((fw && s_rty) ? ob : '0));
      chk("timeout", 128'(timeout_o), 128'(ab));
      chk("m_dat",   128'(m_dat_o), 128'(s_dat));
   endtask

   task automatic model_update();
      logic ab, found;
      int   c;
      ab = m_abort();
      case (md)
         0: begin
            found = 1'b0;
            for (int k = 1; k <= NM; k++) begin
               c = (last_m + k) % NM;
               if (!found && m_cyc[c]) begin
                  found = 1'b1;
                  own   = c;
               end
            end
            if (found) begin
               md     = 1;
               last_m = own;
               stall  = 0;
            end
         end
         1: begin
            if (!m_cyc[own]) begin
               md = 0; own = 0; stall = 0;
            end else if (ab) begin
               md = 2; stall = 0;
            end else if (m_stb[own] && !(s_ack || s_err || s_rty)) begin
               stall++;
            end else begin
               stall = 0;
            end
         end
         default: begin
            if (!m_cyc[own]) begin
               md = 0; own = 0;
            end
         end
      endcase
   endtask

   task automatic model_reset();
      md = 0; own = 0; last_m = NM - 1; stall = 0;
   endtask

   task automatic settle();
      #2;
      compare_outputs();
   endtask

   task automatic clk_edge();
      @(posedge clk);
      #1;
      model_update();
   endtask

   task automatic step();
      settle();
      clk_edge();
   endtask

   task automatic rand_payload();
      logic [95:0]  a96;
      a96   = {$urandom, $urandom, $urandom};
      m_adr = a96[NM*AW-1:0];
      m_dat = {$urandom, $urandom, $urandom, $urandom};
      m_sel = 16'($urandom);
      m_we  = 4'($urandom);
      s_dat = $urandom;
   endtask

   task automatic clear_inputs();
      m_cyc = '0; m_stb = '0; s_ack = 1'b0; s_err = 1'b0; s_rty = 1'b0;
      rand_payload();
   endtask

   task automatic do_reset();
      clear_inputs();
      rst_n = 1'b0;
      model_reset();
      @(posedge clk);
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      settle();
      chk("rst_grant", 128'(grant_o), 128'(0));
      chk("rst_resp", 128'({m_ack_o, m_err_o, m_rty_o, timeout_o, s_cyc_o, s_stb_o}), 128'(0));
      clk_edge();
   endtask

   logic [NM-1:0] order_exp [5];

   initial begin
      rst_n = 1'b0;
      clear_inputs();
      model_reset();

      // Masters 0 and 2 request together; master 0 first, then 2 after a dead cycle.
      do_reset();
      m_cyc = 4'b0101; m_stb = 4'b0101;
      step();
      chk("t1_grant0", 128'(grant_o), 128'(4'b0001));
      m_cyc = 4'b0100; m_stb = 4'b0100;
      step();
      chk("t1_dead", 128'(grant_o), 128'(4'b0000));
      step();
      chk("t1_grant2", 128'(grant_o), 128'(4'b0100));
      m_cyc = '0; m_stb = '0;
      step();
      step();

      // Everyone requests continuously; each owner does a single acked cycle.
      do_reset();
      order_exp = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
      for (int n = 0; n < 5; n++) begin
         m_cyc = 4'b1111; m_stb = '0; s_ack = 1'b0;
         step();
         chk("t2_order", 128'(grant_o), 128'(order_exp[n]));
         m_stb = grant_o; s_ack = 1'b1; rand_payload();
         step();
         s_ack = 1'b0; m_stb = '0; m_cyc = 4'b1111 & ~grant_o;
         step();
         chk("t2_idle", 128'(grant_o), 128'(4'b0000));
      end
      clear_inputs();
      step();

      // Owner 1 reads, ack after 3 stalled cycles, while others wait.
      do_reset();
      m_cyc = 4'b0010; m_stb = 4'b0010; m_we = '0;
      step();
      chk("t3_grant1", 128'(grant_o), 128'(4'b0010));
      m_cyc = 4'b1011;
      m_stb = 4'b1011;
      for (int i = 0; i < 4; i++) begin
         s_ack = (i == 3);
         s_dat = (i == 3) ? 32'hDEAD_BEEF : $urandom;
         settle();
         if (i == 3) begin
            chk("t3_ack",  128'(m_ack_o), 128'(4'b0010));
            chk("t3_data", 128'(m_dat_o), 128'(32'hDEAD_BEEF));
         end else begin
            chk("t3_noack", 128'(m_ack_o), 128'(4'b0000));
         end
         clk_edge();
      end
      s_ack = 1'b0; m_cyc = 4'b1001; m_stb = 4'b1001;
      step();
      step();
      chk("t3_next3", 128'(grant_o), 128'(4'b1000));
      clear_inputs();
      step();
      step();

      // Slave never answers: watchdog abort on the 8th stalled cycle.
      do_reset();
      m_cyc = 4'b0001; m_stb = 4'b0001;
      step();
      for (int i = 1; i <= TMO; i++) begin
         settle();
         chk("t4_timeout", 128'(timeout_o), 128'(i == TMO));
         if (i == TMO) begin
            chk("t4_err",  128'(m_err_o), 128'(4'b0001));
            chk("t4_scyc", 128'(s_cyc_o), 128'(0));
         end
         clk_edge();
      end
      step();
      s_ack = 1'b1;
      settle();
      chk("t4_late_ack", 128'(m_ack_o), 128'(4'b0000));
      clk_edge();
      s_ack = 1'b0; m_cyc = '0; m_stb = '0;
      step();
      chk("t4_idle", 128'(grant_o), 128'(4'b0000));

      // Slave ack coincides with the watchdog limit: ack wins.
      do_reset();
      m_cyc = 4'b0100; m_stb = 4'b0100;
      step();
      for (int i = 1; i <= TMO; i++) begin
         s_ack = (i == TMO);
         settle();
         if (i == TMO) begin
            chk("t5_ack",     128'(m_ack_o), 128'(4'b0100));
            chk("t5_timeout", 128'(timeout_o), 128'(0));
         end
         clk_edge();
      end
      s_ack = 1'b0; m_stb = '0;
      settle();
      chk("t5_still_own", 128'({grant_o, s_cyc_o}), 128'({4'b0100, 1'b1}));
      clk_edge();
      clear_inputs();
      step();

      // Asynchronous reset in the middle of a burst owned by master 3.
      do_reset();
      m_cyc = 4'b1000; m_stb = 4'b1000;
      step();
      for (int i = 0; i < 3; i++) begin
         s_ack = i[0];
         rand_payload();
         step();
      end
      s_ack = 1'b1;
      #2;
      rst_n = 1'b0;
      #1;
      chk("t6_grant_drop", 128'(grant_o), 128'(0));
      chk("t6_scyc_drop",  128'(s_cyc_o), 128'(0));
      chk("t6_no_ack",     128'(m_ack_o), 128'(0));
      model_reset();
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      s_ack = 1'b0;
      m_cyc = 4'b1111; m_stb = '0;
      step();
      chk("t6_first", 128'(grant_o), 128'(4'b0001));
      clear_inputs();
      step();
      step();

      // Random traffic; the slave goes silent for a stretch to provoke aborts.
      do_reset();
      for (int cyc = 0; cyc < 800; cyc++) begin
         logic quiet;
         quiet = (cyc >= 300) && (cyc < 450);
         for (int k = 0; k < NM; k++) begin
            if (m_cyc[k]) begin
               if ($urandom_range(11) == 0) m_cyc[k] = 1'b0;
            end else begin
               m_cyc[k] = ($urandom_range(2) == 0);
            end
            m_stb[k] = m_cyc[k] && ($urandom_range(3) != 0);
         end
         rand_payload();
         s_ack = !quiet && ($urandom_range(4) == 0);
         s_err = !quiet && ($urandom_range(15) == 0);
         s_rty = !quiet && ($urandom_range(15) == 0);
         step();
      end
      clear_inputs();
      step();

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
